// File: rtl/bob_receiver.sv
// Responder end of the secure link: decrypts the peer's DH value, returns its own,
// then decrypts incoming data blocks under the negotiated session key.
module bob_receiver #(
  parameter int unsigned      CNT_W       = 32,
  parameter logic [CNT_W-1:0] REKEY_LIMIT = 32'hFFFF_FFFF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] peer_dh_data,
  input  logic         peer_dh_valid,
  input  logic [127:0] peer_data,
  input  logic         peer_data_valid,
  output logic         o_stb,
  output logic [127:0] bob_dh_data,
  output logic         bob_dh_valid,
  input  logic [127:0] lk_key,
  input  logic         lk_valid,
  output logic         lk_change_rq,
  output logic [127:0] aes_key,
  output logic         aes_key_load,
  output logic [127:0] dec_datain,
  output logic         dec_stb,
  input  logic [127:0] dec_dataout,
  input  logic         dec_valid,
  output logic         dec_release,
  output logic [127:0] enc_datain,
  output logic         enc_stb,
  input  logic [127:0] enc_dataout,
  input  logic         enc_valid,
  output logic         enc_release,
  output logic [63:0]  dh_partner,
  output logic         dh_partner_val,
  input  logic [63:0]  dh_my_key,
  input  logic         dh_my_key_val,
  input  logic [127:0] dh_K,
  input  logic         dh_K_val,
  output logic [127:0] data_out,
  output logic         data_out_valid,
  input  logic         usr_ack,
  output logic         session_active
);

  typedef enum logic [1:0] {IDLE, KEY_GEN, RECEIVE, REKEY} state_t;

  state_t           state;
  logic [CNT_W-1:0] blk_cnt;
  logic [CNT_W-1:0] blk_cnt_inc;
  logic             dec_busy;
  logic             o_stb_pend;
  logic             dh_taken;
  logic             partner_sent;
  logic             lk_low_seen;
  logic             accept;

  assign blk_cnt_inc    = blk_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign session_active = (state == RECEIVE);
  // A fresh block waits until the session key has finished loading.
  assign accept = (state == RECEIVE) && peer_data_valid && !dec_busy &&
                  !data_out_valid && !aes_key_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      blk_cnt        <= '0;
      dec_busy       <= 1'b0;
      o_stb_pend     <= 1'b0;
      dh_taken       <= 1'b0;
      partner_sent   <= 1'b0;
      lk_low_seen    <= 1'b0;
      o_stb          <= 1'b0;
      bob_dh_data    <= '0;
      bob_dh_valid   <= 1'b0;
      lk_change_rq   <= 1'b0;
      aes_key        <= '0;
      aes_key_load   <= 1'b0;
      dec_datain     <= '0;
      dec_stb        <= 1'b0;
      dec_release    <= 1'b0;
      enc_datain     <= '0;
      enc_stb        <= 1'b0;
      enc_release    <= 1'b0;
      dh_partner     <= '0;
      dh_partner_val <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      aes_key_load   <= 1'b0;
      dec_stb        <= 1'b0;
      enc_stb        <= 1'b0;
      dec_release    <= 1'b0;
      enc_release    <= 1'b0;
      dh_partner_val <= 1'b0;
      bob_dh_valid   <= 1'b0;
      o_stb          <= o_stb_pend;
      o_stb_pend     <= 1'b0;

      case (state)
        IDLE: begin
          if (lk_valid && peer_dh_valid) begin
            state        <= KEY_GEN;
            aes_key      <= lk_key;
            aes_key_load <= 1'b1;
            dh_taken     <= 1'b0;
            partner_sent <= 1'b0;
          end
        end

        KEY_GEN: begin
          if (!dh_taken) begin
            dec_datain <= peer_dh_data;
            dec_stb    <= 1'b1;
            dh_taken   <= 1'b1;
          end
          if (dh_taken && dec_valid && !partner_sent) begin
            dh_partner     <= dec_dataout[63:0];
            dh_partner_val <= 1'b1;
            partner_sent   <= 1'b1;
          end
          if (dh_my_key_val) begin
            enc_datain <= {64'b0, dh_my_key};
            enc_stb    <= 1'b1;
          end
          bob_dh_data  <= enc_dataout;
          bob_dh_valid <= enc_valid && !dh_K_val;
          // Session key lives in aes_key for the rest of the session.
          if (dh_K_val) begin
            state        <= RECEIVE;
            aes_key      <= dh_K;
            aes_key_load <= 1'b1;
            dec_release  <= 1'b1;
            enc_release  <= 1'b1;
          end
        end

        RECEIVE: begin
          if (accept) begin
            dec_datain <= peer_data;
            dec_stb    <= 1'b1;
            dec_busy   <= 1'b1;
            o_stb_pend <= 1'b1;
          end
          if (dec_busy && dec_valid && !data_out_valid) begin
            data_out       <= dec_dataout;
            data_out_valid <= 1'b1;
          end
          if (usr_ack && data_out_valid) begin
            data_out_valid <= 1'b0;
            dec_release    <= 1'b1;
            dec_busy       <= 1'b0;
            if (blk_cnt_inc == REKEY_LIMIT) begin
              blk_cnt      <= '0;
              state        <= REKEY;
              lk_change_rq <= 1'b1;
              lk_low_seen  <= 1'b0;
            end else begin
              blk_cnt <= blk_cnt_inc;
            end
          end
        end

        REKEY: begin
          if (!lk_valid) begin
            lk_low_seen <= 1'b1;
          end else if (lk_low_seen) begin
            lk_change_rq <= 1'b0;
            state        <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bob_receiver.sv
// Directed bench for bob_receiver: handshake in both DH orders, data flow,
// rekey at a small limit, mid-session reset and spurious inputs.
module tb_bob_receiver;

  localparam logic [127:0] XK = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
  localparam int W_OSTB = 0, W_DOV = 1, W_PVAL = 2, W_BOBV = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] peer_dh_data, peer_data, lk_key, dec_dataout, enc_dataout, dh_K;
  logic         peer_dh_valid, peer_data_valid, lk_valid, dec_valid, enc_valid;
  logic [63:0]  dh_my_key;
  logic         dh_my_key_val, dh_K_val, usr_ack;
  logic         o_stb, bob_dh_valid, lk_change_rq, aes_key_load, dec_stb, dec_release;
  logic         enc_stb, enc_release, dh_partner_val, data_out_valid, session_active;
  logic [127:0] bob_dh_data, aes_key, dec_datain, enc_datain, data_out;
  logic [63:0]  dh_partner;

  int assertCount = 0;
  int failCount   = 0;
  int decLat      = 1;
  int aesLoadCnt = 0, decStbCnt = 0, encStbCnt = 0, pvalCnt = 0, oStbCnt = 0;
  int bLoad, bDec, bEnc, bPval, bOstb;
  logic [127:0] bk [4];

  always #5 clk = ~clk;

  bob_receiver #(.CNT_W(32), .REKEY_LIMIT(32'd3)) dut (
    .clk(clk), .reset(reset),
    .peer_dh_data(peer_dh_data), .peer_dh_valid(peer_dh_valid),
    .peer_data(peer_data), .peer_data_valid(peer_data_valid), .o_stb(o_stb),
    .bob_dh_data(bob_dh_data), .bob_dh_valid(bob_dh_valid),
    .lk_key(lk_key), .lk_valid(lk_valid), .lk_change_rq(lk_change_rq),
    .aes_key(aes_key), .aes_key_load(aes_key_load),
    .dec_datain(dec_datain), .dec_stb(dec_stb), .dec_dataout(dec_dataout),
    .dec_valid(dec_valid), .dec_release(dec_release),
    .enc_datain(enc_datain), .enc_stb(enc_stb), .enc_dataout(enc_dataout),
    .enc_valid(enc_valid), .enc_release(enc_release),
    .dh_partner(dh_partner), .dh_partner_val(dh_partner_val),
    .dh_my_key(dh_my_key), .dh_my_key_val(dh_my_key_val),
    .dh_K(dh_K), .dh_K_val(dh_K_val),
    .data_out(data_out), .data_out_valid(data_out_valid), .usr_ack(usr_ack),
    .session_active(session_active)
  );

  // Pulse counters, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (aes_key_load)   aesLoadCnt++;
      if (dec_stb)        decStbCnt++;
      if (enc_stb)        encStbCnt++;
      if (dh_partner_val) pvalCnt++;
      if (o_stb)          oStbCnt++;
    end
  end

  // Decryptor stand-in: XOR with XK after decLat cycles, held until released.
  initial begin : dec_model
    int waitLeft;
    logic pend;
    logic [127:0] latched;
    dec_valid = 1'b0; dec_dataout = '0; pend = 1'b0; waitLeft = 0; latched = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        dec_valid = 1'b0; pend = 1'b0;
      end else begin
        if (dec_release) dec_valid = 1'b0;
        if (dec_stb) begin
          pend = 1'b1; waitLeft = decLat; latched = dec_datain;
        end else if (pend) begin
          waitLeft--;
          if (waitLeft <= 0) begin
            dec_valid = 1'b1; dec_dataout = latched ^ XK; pend = 1'b0;
          end
        end
      end
    end
  end

  initial begin : enc_model
    enc_valid = 1'b0; enc_dataout = '0;
    forever begin
      @(negedge clk);
      if (reset) enc_valid = 1'b0;
      else begin
        if (enc_release) enc_valid = 1'b0;
        if (enc_stb) begin enc_valid = 1'b1; enc_dataout = enc_datain ^ XK; end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic lkv, input logic pdhv, input logic pdv);
    lk_valid = lkv; peer_dh_valid = pdhv; peer_data_valid = pdv;
    nextCycle();
  endtask

  function automatic logic sigSel(input int which);
    case (which)
      W_OSTB:  return o_stb;
      W_DOV:   return data_out_valid;
      W_PVAL:  return dh_partner_val;
      default: return bob_dh_valid;
    endcase
  endfunction

  task automatic waitFor(input string tag, input int which, input int limit);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < limit; k++) begin
      nextCycle();
      if (sigSel(which)) begin hit = 1'b1; break; end
    end
    checkOutput(tag, 128'(hit), 128'd1);
  endtask

  task automatic snapshot();
    bLoad = aesLoadCnt; bDec = decStbCnt; bEnc = encStbCnt; bPval = pvalCnt; bOstb = oStbCnt;
  endtask

  initial begin
    bk[0] = 128'h1111_0000_AAAA_5555_0123_4567_89AB_CDEF;
    bk[1] = 128'h2222_0000_BBBB_6666_FEDC_BA98_7654_3210;
    bk[2] = 128'h3333_0000_CCCC_7777_0F0F_F0F0_1234_5678;
    bk[3] = 128'h4444_0000_DDDD_8888_DEAD_BEEF_CAFE_F00D;
    reset = 1'b1; peer_dh_data = XK ^ 128'h5; peer_data = '0; lk_key = '0;
    peer_dh_valid = 1'b0; peer_data_valid = 1'b0; lk_valid = 1'b0;
    dh_my_key = '0; dh_my_key_val = 1'b0; dh_K = '0; dh_K_val = 1'b0; usr_ack = 1'b0;
    repeat (3) nextCycle();
    checkOutput("rst_aes_key", aes_key, 128'd0);
    checkOutput("rst_aes_load", 128'(aes_key_load), 128'd0);
    checkOutput("rst_session", 128'(session_active), 128'd0);
    checkOutput("rst_dov", 128'(data_out_valid), 128'd0);
    checkOutput("rst_lk_rq", 128'(lk_change_rq), 128'd0);
    reset = 1'b0;

    // Spurious usr_ack / peer_data_valid in IDLE.
    snapshot();
    usr_ack = 1'b1;
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1);
    usr_ack = 1'b0;
    peer_data_valid = 1'b0;
    checkOutput("idle_session", 128'(session_active), 128'd0);
    checkOutput("idle_ostb_cnt", 128'(oStbCnt - bOstb), 128'd0);
    checkOutput("idle_decstb_cnt", 128'(decStbCnt - bDec), 128'd0);

    // Handshake, partner DH first.
    snapshot();
    lk_key = 128'h82;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("hs_aes_key", aes_key, 128'h82);
    checkOutput("hs_aes_load", 128'(aes_key_load), 128'd1);
    nextCycle();
    checkOutput("hs_dec_stb", 128'(dec_stb), 128'd1);
    checkOutput("hs_dec_datain", dec_datain, XK ^ 128'h5);
    peer_dh_valid = 1'b0;
    waitFor("hs_wait_pval", W_PVAL, 20);
    checkOutput("hs_dh_partner", 128'(dh_partner), 128'd5);
    repeat (3) nextCycle();
    checkOutput("hs_pval_cnt", 128'(pvalCnt - bPval), 128'd1);
    dh_my_key = 64'h9; dh_my_key_val = 1'b1;
    nextCycle();
    dh_my_key_val = 1'b0;
    checkOutput("hs_enc_stb", 128'(enc_stb), 128'd1);
    checkOutput("hs_enc_datain", enc_datain, 128'h9);
    waitFor("hs_wait_bobv", W_BOBV, 20);
    checkOutput("hs_bob_dh_data", bob_dh_data, XK ^ 128'h9);
    dh_K = 128'hABCD; dh_K_val = 1'b1;
    nextCycle();
    dh_K_val = 1'b0;
    checkOutput("hs_session", 128'(session_active), 128'd1);
    checkOutput("hs_session_key", aes_key, 128'hABCD);
    checkOutput("hs_key_reload", 128'(aes_key_load), 128'd1);
    checkOutput("hs_releases", 128'({dec_release, enc_release}), 128'd3);
    checkOutput("hs_load_cnt", 128'(aesLoadCnt - bLoad), 128'd2);
    checkOutput("hs_decstb_cnt", 128'(decStbCnt - bDec), 128'd1);

    // Spurious dh_K_val in RECEIVE.
    dh_K = 128'h1234; dh_K_val = 1'b1;
    nextCycle();
    dh_K_val = 1'b0;
    nextCycle();
    checkOutput("spur_k_key", aes_key, 128'hABCD);
    checkOutput("spur_k_session", 128'(session_active), 128'd1);

    // Three blocks back to back, a 4th left pending at the rekey limit.
    snapshot();
    decLat = 2;
    peer_data = bk[0]; peer_data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      waitFor("df_wait_ostb", W_OSTB, 20);
      peer_data = bk[i+1];
      waitFor("df_wait_dov", W_DOV, 20);
      checkOutput("df_data_out", data_out, bk[i] ^ XK);
      repeat (5) nextCycle();
      checkOutput("df_decstb_cnt", 128'(decStbCnt - bDec), 128'(i + 1));
      checkOutput("df_ostb_cnt", 128'(oStbCnt - bOstb), 128'(i + 1));
      usr_ack = 1'b1;
      nextCycle();
      usr_ack = 1'b0;
    end
    checkOutput("rk_lk_rq", 128'(lk_change_rq), 128'd1);
    checkOutput("rk_session", 128'(session_active), 128'd0);
    lk_valid = 1'b0;
    repeat (2) nextCycle();
    checkOutput("rk_lk_rq_held", 128'(lk_change_rq), 128'd1);
    lk_valid = 1'b1;
    nextCycle();
    checkOutput("rk_lk_rq_drop", 128'(lk_change_rq), 128'd0);
    repeat (4) nextCycle();
    checkOutput("rk_no_4th_ostb", 128'(oStbCnt - bOstb), 128'd3);
    checkOutput("rk_idle_no_load", 128'(aesLoadCnt - bLoad), 128'd0);
    peer_data_valid = 1'b0;

    // Handshake again, own DH key well ahead of the partner's.
    snapshot();
    decLat = 12;
    lk_key = 128'h77;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("rv_aes_key", aes_key, 128'h77);
    nextCycle();
    peer_dh_valid = 1'b0;
    dh_my_key = 64'h9; dh_my_key_val = 1'b1;
    nextCycle();
    dh_my_key_val = 1'b0;
    checkOutput("rv_enc_stb", 128'(enc_stb), 128'd1);
    checkOutput("rv_pval_early", 128'(pvalCnt - bPval), 128'd0);
    waitFor("rv_wait_pval", W_PVAL, 30);
    checkOutput("rv_dh_partner", 128'(dh_partner), 128'd5);
    repeat (3) nextCycle();
    checkOutput("rv_pval_cnt", 128'(pvalCnt - bPval), 128'd1);
    checkOutput("rv_encstb_cnt", 128'(encStbCnt - bEnc), 128'd1);
    checkOutput("rv_bob_dh_valid", 128'(bob_dh_valid), 128'd1);
    dh_K = 128'h5A5A; dh_K_val = 1'b1;
    nextCycle();
    dh_K_val = 1'b0;
    checkOutput("rv_session", 128'(session_active), 128'd1);
    checkOutput("rv_session_key", aes_key, 128'h5A5A);

    // Reset while a block is waiting for the user.
    decLat = 1;
    peer_data = bk[2]; peer_data_valid = 1'b1;
    waitFor("mr_wait_ostb", W_OSTB, 20);
    peer_data_valid = 1'b0;
    waitFor("mr_wait_dov", W_DOV, 20);
    reset = 1'b1;
    nextCycle();
    checkOutput("mr_dov", 128'(data_out_valid), 128'd0);
    checkOutput("mr_data_out", data_out, 128'd0);
    checkOutput("mr_session", 128'(session_active), 128'd0);
    checkOutput("mr_aes_key", aes_key, 128'd0);
    checkOutput("mr_dec_datain", dec_datain, 128'd0);
    checkOutput("mr_dh_partner", 128'(dh_partner), 128'd0);
    reset = 1'b0;
    repeat (2) nextCycle();
    checkOutput("mr_stays_idle", 128'(session_active), 128'd0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/bob_receiver.md
Name: bob_receiver

Overview:
- Responder end of the secure link: the counterpart of the transmitting node.
- Takes the peer's AES-encrypted Diffie-Hellman public value and decrypts it with the long-term key. Returns its own DH public value, encrypted with the same key.
- Latches the resulting session key, then decrypts incoming data blocks for the user and strobes o_stb back to the peer per accepted block.
- After REKEY_LIMIT blocks it requests a long-key change. Controls external AES encrypt/decrypt cores and a DH core through the ports below.

Parameters:
- CNT_W, 32, width of the accepted-block counter.
- REKEY_LIMIT, 32'hFFFF_FFFF, block count that triggers a rekey.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- peer_dh_data  in  128  encrypted peer DH public value
- peer_dh_valid  in  1  peer_dh_data valid (held until consumed)
- peer_data  in  128  encrypted data block
- peer_data_valid  in  1  peer_data valid (held until o_stb)
- o_stb  out  1  1-cycle pulse: peer_data block consumed
- bob_dh_data  out  128  encrypted own DH public value
- bob_dh_valid  out  1  bob_dh_data valid
- lk_key  in  128  long-term key from key container
- lk_valid  in  1  long key valid
- lk_change_rq  out  1  long-key change request
- aes_key  out  128  key to both AES cores
- aes_key_load  out  1  1-cycle key-expansion load pulse
- dec_datain  out  128  decryptor input
- dec_stb  out  1  decryptor input strobe
- dec_dataout  in  128  decryptor result
- dec_valid  in  1  decryptor result valid (held until dec_release)
- dec_release  out  1  1-cycle pulse freeing decryptor output
- enc_datain  out  128  encryptor input
- enc_stb  out  1  encryptor input strobe
- enc_dataout  in  128  encryptor result
- enc_valid  in  1  encryptor result valid (held until enc_release)
- enc_release  out  1  1-cycle pulse freeing encryptor output
- dh_partner  out  64  decrypted peer DH value
- dh_partner_val  out  1  1-cycle strobe
- dh_my_key  in  64  own DH public value
- dh_my_key_val  in  1  1-cycle strobe
- dh_K  in  128  shared session key
- dh_K_val  in  1  1-cycle strobe
- data_out  out  128  plaintext block
- data_out_valid  out  1  held until usr_ack
- usr_ack  in  1  user accepts data_out
- session_active  out  1  high in RECEIVE

Behaviour:
- Reset: state IDLE, block counter 0, session key 0, pending flags 0. All outputs 0; aes_key = 0.
- Reset wins over every other event in the same cycle and aborts any state.
- States: IDLE, KEY_GEN, RECEIVE, REKEY.
- IDLE -> KEY_GEN when lk_valid & peer_dh_valid. On this edge aes_key <= lk_key and aes_key_load pulses 1 cycle.
- KEY_GEN, inbound path:
  - dec_datain = peer_dh_data; dec_stb pulses once, the cycle after entry. The DH block is taken only once per KEY_GEN.
  - When dec_valid, drive dh_partner = dec_dataout[63:0] and pulse dh_partner_val 1 cycle. Not re-sent while dec_valid stays high.
- KEY_GEN, outbound path:
  - On dh_my_key_val, enc_datain = {64'b0, dh_my_key} with enc_stb in the same cycle.
  - bob_dh_data = enc_dataout; bob_dh_valid = KEY_GEN & enc_valid.
- The two paths are independent; either order of dh_my_key_val vs dh_partner_val is legal.
- KEY_GEN -> RECEIVE on dh_K_val. Same edge:
  - session key <= dh_K; aes_key <= dh_K; aes_key_load pulses next cycle.
  - dec_release and enc_release pulse 1 cycle.
- RECEIVE accepts a block when peer_data_valid & !dec_busy & !data_out_valid & !aes_key_load:
  - dec_datain = peer_data; dec_stb pulses; o_stb pulses the following cycle; dec_busy set.
  - Exactly one o_stb per accepted block.
- On dec_valid in RECEIVE, data_out <= dec_dataout and data_out_valid <= 1 (registered, 1 cycle).
- When usr_ack & data_out_valid:
  - data_out_valid clears; dec_release pulses; dec_busy clears.
  - Counter increments, wrapping at 2^CNT_W.
  - usr_ack while data_out_valid = 0 is ignored.
- Rekey trigger: when the incremented count equals REKEY_LIMIT, go RECEIVE -> REKEY. Counter resets to 0 and lk_change_rq <= 1.
- A block whose peer_data_valid is pending at the limit is not accepted.
- REKEY: lk_change_rq held high until lk_valid has been seen low for at least 1 cycle and then high. Then lk_change_rq <= 0 and go to IDLE.
- lk_valid already low on entry counts as the low phase.
- session_active = (state == RECEIVE).
- Unused strobes are 0 outside their states; data buses may hold stale values when their valid is low.

Test Plan:
- Handshake: reset, lk_key=128'h82, lk_valid=1, peer_dh_valid=1. Expect:
  - aes_key=128'h82 with a single aes_key_load pulse, one dec_stb.
  - dec_valid with dec_dataout[63:0]=64'h5 -> dh_partner=5, dh_partner_val 1 cycle.
  - dh_my_key_val, dh_my_key=64'h9 -> enc_datain=128'h9.
  - enc_valid -> bob_dh_valid=1.
  - dh_K_val with dh_K=128'hABCD -> RECEIVE, aes_key=128'hABCD, release pulses, session_active=1.
- Reversed DH order: dh_my_key_val arrives 10 cycles before dec_valid -> same final state; exactly one enc_stb and one dh_partner_val.
- Data flow: 3 back-to-back peer_data blocks, usr_ack delayed 5 cycles each. Expect:
  - One o_stb per block, data_out equal to each dec_dataout, in order.
  - No second dec_stb before the matching usr_ack.
- Rekey with REKEY_LIMIT=3: after the 3rd usr_ack, state REKEY and lk_change_rq=1. Then lk_valid low 2 cycles, high -> lk_change_rq=0, IDLE; 4th pending block gets no o_stb.
- Reset mid-RECEIVE with data_out_valid=1: next cycle all outputs 0, counter 0, session_active=0.
- Spurious inputs: usr_ack in IDLE, dh_K_val in RECEIVE, peer_data_valid in IDLE -> no state change, no o_stb.
